// File: rtl/bram_pingpong_ring.sv
// bram_pingpong_ring: multi-bank segment buffer that fills banks in round-robin order and drains them in the same order.
// Ports: clk/rstn clock and async active-low reset; flush returns every bank to EMPTY.
//   Fill side: seg_words, fill_req, fill_we/addr/wdata/be in; fill_busy, fill_done, fill_bank out.
//   Consume side: consume_req, rd_en/rd_addr, cons_commit in; rd_rdata, rd_valid, consume_busy, consume_done, cons_bank out.
//   Status: full_cnt and empty_cnt give the number of FULL and EMPTY banks.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
module bram_pingpong_ring #(
    parameter int DATA_W          = `AXI_DATA_WIDTH,
    parameter int DEPTH           = 64,
    parameter int NUM_BANKS       = 2,
    parameter int USE_CONS_COMMIT = 1,
    localparam int ADDR_W         = $clog2(DEPTH),
    localparam int BW             = $clog2(NUM_BANKS),
    localparam int CW             = $clog2(NUM_BANKS + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [31:0]         seg_words,
    input  logic                fill_req,
    input  logic                fill_we,
    input  logic [ADDR_W-1:0]   fill_addr,
    input  logic [DATA_W-1:0]   fill_wdata,
    input  logic [DATA_W/8-1:0] fill_be,
    output logic                fill_busy,
    output logic                fill_done,
    input  logic                consume_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic                rd_en,
    output logic [DATA_W-1:0]   rd_rdata,
    output logic                rd_valid,
    input  logic                cons_commit,
    output logic                consume_busy,
    output logic                consume_done,
    input  logic                flush,
    output logic [BW-1:0]       fill_bank,
    output logic [BW-1:0]       cons_bank,
    output logic [CW-1:0]       full_cnt,
    output logic [CW-1:0]       empty_cnt
);
    localparam int LW = ADDR_W + 1;
    typedef enum logic [1:0] {EMPTY, FILL, FULL, ACTIVE} bank_state_t;
    bank_state_t       state   [NUM_BANKS];
    logic [LW-1:0]     seg_len [NUM_BANKS];
    logic [DATA_W-1:0] mem     [NUM_BANKS][DEPTH];
    logic [LW-1:0]     wcnt, rcnt, seg_eff;
    logic [BW-1:0]     wr_ptr, rd_ptr;
    logic              fill_start, fill_fin, cons_start, rd_hit, cons_fin;
    assign seg_eff    = (seg_words == 32'd0 || seg_words > DEPTH) ? LW'(DEPTH) : LW'(seg_words);
    assign fill_start = !fill_busy && fill_req && state[wr_ptr] == EMPTY;
    assign fill_fin   = fill_busy && fill_we && (wcnt + LW'(1)) == seg_len[wr_ptr];
    assign cons_start = !consume_busy && consume_req && state[rd_ptr] == FULL;
    assign rd_hit     = consume_busy && rd_en;
    assign cons_fin   = consume_busy && ((USE_CONS_COMMIT != 0) ? cons_commit
                                         : rd_en && (rcnt + LW'(1)) == seg_len[rd_ptr]);
    assign fill_bank  = wr_ptr;
    assign cons_bank  = rd_ptr;
    // Storage has no reset so it maps onto block RAM; flush leaves contents intact.
    always_ff @(posedge clk) begin
        if (fill_busy && fill_we && !flush)
            for (int b = 0; b < DATA_W / 8; b++)
                if (fill_be[b]) mem[wr_ptr][fill_addr][b*8 +: 8] <= fill_wdata[b*8 +: 8];
    end
    // Fill and consume act on different banks by construction (a fill owns a FILL/EMPTY bank,
    // a consume owns a FULL/ACTIVE bank), so both sides update state[] independently.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                state[i]   <= EMPTY;
                seg_len[i] <= '0;
            end
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wcnt         <= '0;
            rcnt         <= '0;
            fill_busy    <= 1'b0;
            fill_done    <= 1'b0;
            consume_busy <= 1'b0;
            consume_done <= 1'b0;
            rd_valid     <= 1'b0;
            rd_rdata     <= '0;
            full_cnt     <= '0;
            empty_cnt    <= CW'(NUM_BANKS);
        end else if (flush) begin
            for (int i = 0; i < NUM_BANKS; i++) state[i] <= EMPTY;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_busy    <= 1'b0;
            fill_done    <= 1'b0;
            consume_busy <= 1'b0;
            consume_done <= 1'b0;
            rd_valid     <= 1'b0;
            full_cnt     <= '0;
            empty_cnt    <= CW'(NUM_BANKS);
        end else begin
            fill_done    <= fill_fin;
            consume_done <= cons_fin;
            rd_valid     <= rd_hit;
            if (rd_hit) rd_rdata <= mem[rd_ptr][rd_addr];
            if (fill_start) begin
                state[wr_ptr]   <= FILL;
                seg_len[wr_ptr] <= seg_eff;
                wcnt            <= '0;
                fill_busy       <= 1'b1;
            end else if (fill_busy && fill_we) begin
                wcnt <= wcnt + LW'(1);
                if (fill_fin) begin
                    state[wr_ptr] <= FULL;
                    fill_busy     <= 1'b0;
                    wr_ptr        <= (wr_ptr == BW'(NUM_BANKS - 1)) ? '0 : wr_ptr + 1'b1;
                end
            end
            if (cons_start) begin
                state[rd_ptr] <= ACTIVE;
                rcnt          <= '0;
                consume_busy  <= 1'b1;
            end else if (consume_busy) begin
                if (rd_en) rcnt <= rcnt + LW'(1);
                if (cons_fin) begin
                    state[rd_ptr] <= EMPTY;
                    consume_busy  <= 1'b0;
                    rd_ptr        <= (rd_ptr == BW'(NUM_BANKS - 1)) ? '0 : rd_ptr + 1'b1;
                end
            end
            // Counts track the same events that move banks between states, so they stay exact.
            full_cnt  <= full_cnt + CW'(fill_fin) - CW'(cons_start);
            empty_cnt <= empty_cnt + CW'(cons_fin) - CW'(fill_start);
        end
    end
endmodule

// File: tb/tb_bram_pingpong_ring.sv
// tb_bram_pingpong_ring: directed bench for bram_pingpong_ring in commit mode (3 banks) and read-count mode (2 banks).
module tb_bram_pingpong_ring;
    logic        clk, rstn, fill_req, fill_we, consume_req, rd_en, cons_commit, flush;
    logic [31:0] seg_words, fill_wdata;
    logic [5:0]  fill_addr, rd_addr;
    logic [3:0]  fill_be;
    logic        a_fill_busy, a_fill_done, a_consume_busy, a_consume_done, a_rd_valid;
    logic [31:0] a_rd_rdata;
    logic [1:0]  a_fill_bank, a_cons_bank, a_full_cnt, a_empty_cnt;
    logic        b_fill_busy, b_fill_done, b_consume_busy, b_consume_done, b_rd_valid;
    logic [31:0] b_rd_rdata;
    logic        b_fill_bank, b_cons_bank;
    logic [1:0]  b_full_cnt, b_empty_cnt;
    int          total = 0;
    int          bad = 0;

    bram_pingpong_ring #(.DATA_W(32), .DEPTH(64), .NUM_BANKS(3), .USE_CONS_COMMIT(1)) u_a (
        .clk(clk), .rstn(rstn), .seg_words(seg_words), .fill_req(fill_req), .fill_we(fill_we),
        .fill_addr(fill_addr), .fill_wdata(fill_wdata), .fill_be(fill_be), .fill_busy(a_fill_busy),
        .fill_done(a_fill_done), .consume_req(consume_req), .rd_addr(rd_addr), .rd_en(rd_en),
        .rd_rdata(a_rd_rdata), .rd_valid(a_rd_valid), .cons_commit(cons_commit),
        .consume_busy(a_consume_busy), .consume_done(a_consume_done), .flush(flush),
        .fill_bank(a_fill_bank), .cons_bank(a_cons_bank), .full_cnt(a_full_cnt), .empty_cnt(a_empty_cnt));

    bram_pingpong_ring #(.DATA_W(32), .DEPTH(64), .NUM_BANKS(2), .USE_CONS_COMMIT(0)) u_b (
        .clk(clk), .rstn(rstn), .seg_words(seg_words), .fill_req(fill_req), .fill_we(fill_we),
        .fill_addr(fill_addr), .fill_wdata(fill_wdata), .fill_be(fill_be), .fill_busy(b_fill_busy),
        .fill_done(b_fill_done), .consume_req(consume_req), .rd_addr(rd_addr), .rd_en(rd_en),
        .rd_rdata(b_rd_rdata), .rd_valid(b_rd_valid), .cons_commit(cons_commit),
        .consume_busy(b_consume_busy), .consume_done(b_consume_done), .flush(flush),
        .fill_bank(b_fill_bank), .cons_bank(b_cons_bank), .full_cnt(b_full_cnt), .empty_cnt(b_empty_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        tick;
        rstn = 1'b1;
        tick;
    endtask

    task automatic start_fill(input logic [31:0] sw);
        seg_words = sw;
        fill_req = 1'b1;
        tick;
        fill_req = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        fill_we = 1'b1;
        fill_addr = 6'(a);
        fill_wdata = d;
        fill_be = be;
        tick;
        fill_we = 1'b0;
    endtask

    task automatic rd(input int a);
        rd_en = 1'b1;
        rd_addr = 6'(a);
        tick;
        rd_en = 1'b0;
    endtask

    task automatic arm;
        consume_req = 1'b1;
        tick;
        consume_req = 1'b0;
    endtask

    task automatic commit;
        cons_commit = 1'b1;
        tick;
        cons_commit = 1'b0;
    endtask

    task automatic fill_seg(input int k);
        start_fill(2);
        wr(0, 32'h1000 * (k + 1), 4'hF);
        wr(1, 32'h1000 * (k + 1) + 1, 4'hF);
    endtask

    initial begin
        rstn = 1'b0; seg_words = '0; fill_req = 1'b0; fill_we = 1'b0; fill_addr = '0;
        fill_wdata = '0; fill_be = '0; consume_req = 1'b0; rd_addr = '0; rd_en = 1'b0;
        cons_commit = 1'b0; flush = 1'b0;
        tick;
        tick;
        chk("rst_fill_busy", 32'(a_fill_busy), 0);
        chk("rst_fill_done", 32'(a_fill_done), 0);
        chk("rst_cons_busy", 32'(a_consume_busy), 0);
        chk("rst_rd_valid", 32'(a_rd_valid), 0);
        chk("rst_rd_rdata", a_rd_rdata, 0);
        chk("rst_full_cnt", 32'(a_full_cnt), 0);
        chk("rst_empty_cnt", 32'(a_empty_cnt), 3);
        chk("rst_fill_bank", 32'(a_fill_bank), 0);
        chk("rst_cons_bank", 32'(a_cons_bank), 0);
        chk("rst_b_empty_cnt", 32'(b_empty_cnt), 2);
        rstn = 1'b1;
        tick;
        // Strobes with no segment open are ignored.
        wr(0, 32'hDEAD_BEEF, 4'hF);
        rd(0);
        chk("idle_rd_valid", 32'(a_rd_valid), 0);
        commit;
        chk("idle_cons_done", 32'(a_consume_done), 0);
        chk("idle_empty_cnt", 32'(a_empty_cnt), 3);

        // Three full-length segments, data = addr + 64*k.
        for (int k = 0; k < 3; k++) begin
            start_fill(0);
            chk("fill_busy_set", 32'(a_fill_busy), 1);
            chk("fill_bank_k", 32'(a_fill_bank), 32'(k));
            for (int i = 0; i < 64; i++) wr(i, 32'(i + 64 * k), 4'hF);
            chk("fill_done_pulse", 32'(a_fill_done), 1);
            chk("fill_busy_clr", 32'(a_fill_busy), 0);
            tick;
            chk("fill_done_low", 32'(a_fill_done), 0);
        end
        chk("three_full_cnt", 32'(a_full_cnt), 3);
        chk("three_empty_cnt", 32'(a_empty_cnt), 0);
        chk("three_fill_bank", 32'(a_fill_bank), 0);
        start_fill(0);
        chk("fourth_dropped", 32'(a_fill_busy), 0);
        chk("fourth_full_cnt", 32'(a_full_cnt), 3);

        arm;
        chk("arm_busy", 32'(a_consume_busy), 1);
        chk("arm_bank", 32'(a_cons_bank), 0);
        chk("arm_full_cnt", 32'(a_full_cnt), 2);
        rd(5);
        chk("rd5_valid", 32'(a_rd_valid), 1);
        chk("rd5_data", a_rd_rdata, 5);
        tick;
        chk("rd_valid_low", 32'(a_rd_valid), 0);
        chk("rd_data_hold", a_rd_rdata, 5);
        // Read issued in the same cycle as the commit still returns data.
        rd_en = 1'b1; rd_addr = 6'd10; cons_commit = 1'b1;
        tick;
        rd_en = 1'b0; cons_commit = 1'b0;
        chk("last_rd_valid", 32'(a_rd_valid), 1);
        chk("last_rd_data", a_rd_rdata, 10);
        chk("commit_done", 32'(a_consume_done), 1);
        chk("commit_busy", 32'(a_consume_busy), 0);
        chk("commit_bank", 32'(a_cons_bank), 1);
        chk("commit_empty", 32'(a_empty_cnt), 1);
        tick;
        chk("commit_done_low", 32'(a_consume_done), 0);
        arm;
        rd(3);
        chk("bank1_data", a_rd_rdata, 67);
        commit;
        arm;
        rd(63);
        chk("bank2_data", a_rd_rdata, 191);
        commit;
        chk("drain_empty", 32'(a_empty_cnt), 3);

        // Byte enables.
        do_reset;
        start_fill(2);
        wr(0, 32'hAABB_CCDD, 4'hF);
        wr(0, 32'h1122_3344, 4'h5);
        chk("be_fill_done", 32'(a_fill_done), 1);
        arm;
        rd(0);
        chk("be_data", a_rd_rdata, 32'hAA22_CC44);
        chk("be_b_data", b_rd_rdata, 32'hAA22_CC44);

        // Read-count completion on the 2-bank instance.
        do_reset;
        start_fill(5);
        for (int i = 0; i < 5; i++) wr(i, 32'(100 + i), 4'hF);
        chk("b_fill_done", 32'(b_fill_done), 1);
        arm;
        chk("b_arm_busy", 32'(b_consume_busy), 1);
        for (int i = 0; i < 5; i++) begin
            rd(i);
            chk("b_rd_valid", 32'(b_rd_valid), 1);
            chk("b_rd_data", b_rd_rdata, 32'(100 + i));
            chk("b_cons_done", 32'(b_consume_done), 32'(i == 4));
        end
        chk("b_busy_clr", 32'(b_consume_busy), 0);
        chk("b_empty_cnt", 32'(b_empty_cnt), 2);
        chk("b_full_cnt", 32'(b_full_cnt), 0);
        tick;
        chk("b_done_low", 32'(b_consume_done), 0);

        // consume_req in the completing cycle is too early; the next cycle arms.
        do_reset;
        start_fill(2);
        wr(0, 32'h55, 4'hF);
        fill_we = 1'b1; fill_addr = 6'd1; consume_req = 1'b1;
        tick;
        fill_we = 1'b0; consume_req = 1'b0;
        chk("n_fill_done", 32'(a_fill_done), 1);
        chk("n_not_armed", 32'(a_consume_busy), 0);
        chk("n_full_cnt", 32'(a_full_cnt), 1);
        arm;
        chk("n1_armed", 32'(a_consume_busy), 1);
        chk("n1_cons_bank", 32'(a_cons_bank), 0);
        chk("n1_full_cnt", 32'(a_full_cnt), 0);

        // Fill of bank1 and commit of bank0 finish in the same cycle.
        start_fill(2);
        wr(0, 32'h66, 4'hF);
        fill_we = 1'b1; fill_addr = 6'd1; cons_commit = 1'b1;
        tick;
        fill_we = 1'b0; cons_commit = 1'b0;
        chk("cc_fill_done", 32'(a_fill_done), 1);
        chk("cc_cons_done", 32'(a_consume_done), 1);
        chk("cc_full_cnt", 32'(a_full_cnt), 1);
        chk("cc_empty_cnt", 32'(a_empty_cnt), 2);
        chk("cc_fill_bank", 32'(a_fill_bank), 2);
        chk("cc_cons_bank", 32'(a_cons_bank), 1);

        // Ten segments stay in FIFO order with up to three in flight.
        do_reset;
        fill_seg(0);
        fill_seg(1);
        for (int k = 0; k < 10; k++) begin
            if (k + 2 < 10) fill_seg(k + 2);
            arm;
            chk("fifo_bank", 32'(a_cons_bank), 32'(k % 3));
            rd(1);
            chk("fifo_data", a_rd_rdata, 32'h1000 * (k + 1) + 1);
            commit;
        end
        chk("fifo_empty", 32'(a_empty_cnt), 3);

        // Flush mid-fill, then reset mid-consume.
        do_reset;
        fill_seg(0);
        start_fill(4);
        wr(0, 32'h77, 4'hF);
        wr(1, 32'h78, 4'hF);
        chk("pre_flush_bank", 32'(a_fill_bank), 1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush_fill_busy", 32'(a_fill_busy), 0);
        chk("flush_fill_done", 32'(a_fill_done), 0);
        chk("flush_fill_bank", 32'(a_fill_bank), 0);
        chk("flush_full_cnt", 32'(a_full_cnt), 0);
        chk("flush_empty_cnt", 32'(a_empty_cnt), 3);
        wr(2, 32'h79, 4'hF);
        chk("post_flush_idle", 32'(a_fill_busy), 0);
        start_fill(2);
        wr(1, 32'h88, 4'hF);
        wr(1, 32'h89, 4'hF);
        arm;
        rd(0);
        chk("flush_keeps_mem", a_rd_rdata, 32'h1000);
        chk("mid_cons_busy", 32'(a_consume_busy), 1);
        rstn = 1'b0;
        #2;
        chk("arst_cons_busy", 32'(a_consume_busy), 0);
        chk("arst_rd_valid", 32'(a_rd_valid), 0);
        chk("arst_empty_cnt", 32'(a_empty_cnt), 3);
        chk("arst_fill_bank", 32'(a_fill_bank), 0);
        chk("arst_cons_bank", 32'(a_cons_bank), 0);
        tick;
        rstn = 1'b1;
        tick;
        chk("arst_no_done", 32'(a_consume_done), 0);
        chk("arst_no_fill_done", 32'(a_fill_done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
